// File: rtl/ip_tx_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ip_tx_arbiter_pkg : shared IP TX/RX encodings and sizing        | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ip_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GNT_UDP  = 2'd1,
    ST_GNT_ICMP = 2'd2,
    ST_DRAIN    = 2'd3
  } arb_state_t;

  // tdest encoding shared with the RX demux
  localparam logic TDEST_UDP  = 1'b0;
  localparam logic TDEST_ICMP = 1'b1;

  localparam int MTU_BYTES         = 1500;
  localparam int DEF_MAX_PKT_BEATS = MTU_BYTES / 4;

  // slice payload: {tdest, tlast, tdata}
  localparam int SLICE_W = 1 + 1 + 32;

endpackage

`default_nettype wire

// File: rtl/axis_reg_slice.sv
// ---------------------------------------------------------------------------
// axis_reg_slice : 2-entry skid buffer with registered s_ready     | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module axis_reg_slice #(
  parameter int WIDTH = 34
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
);

  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic             m_valid_nxt;
  logic [WIDTH-1:0] m_data_nxt;
  logic             skid_valid_nxt;
  logic [WIDTH-1:0] skid_data_nxt;
  logic             s_fire;

  assign s_fire = s_valid & s_ready;

  always_comb begin
    m_valid_nxt    = m_valid;
    m_data_nxt     = m_data;
    skid_valid_nxt = skid_valid;
    skid_data_nxt  = skid_data;
    if (m_ready || !m_valid) begin
      // s_ready is low whenever the skid entry is occupied, so no new beat competes here
      if (skid_valid) begin
        m_valid_nxt    = 1'b1;
        m_data_nxt     = skid_data;
        skid_valid_nxt = 1'b0;
      end else begin
        m_valid_nxt = s_fire;
        if (s_fire) begin
          m_data_nxt = s_data;
        end
      end
    end else if (s_fire) begin
      skid_valid_nxt = 1'b1;
      skid_data_nxt  = s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid    <= 1'b0;
      m_data     <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      s_ready    <= 1'b0;
    end else begin
      m_valid    <= m_valid_nxt;
      m_data     <= m_data_nxt;
      skid_valid <= skid_valid_nxt;
      skid_data  <= skid_data_nxt;
      s_ready    <= ~skid_valid_nxt;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ip_tx_arbiter.sv
// ---------------------------------------------------------------------------
// ip_tx_arbiter : packet-level UDP/ICMP arbiter onto the IP TX path | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ip_tx_arbiter
  import ip_tx_arbiter_pkg::*;
#(
  parameter int MAX_PKT_BEATS = DEF_MAX_PKT_BEATS,
  parameter bit FIXED_PRIO    = 1'b0,
  parameter int CNT_W         = 16
) (
  input  logic             tx_mac_aclk,
  input  logic             tx_mac_reset,
  input  logic [31:0]      tx_axis_udp_tdata,
  input  logic             tx_axis_udp_tvalid,
  input  logic             tx_axis_udp_tlast,
  output logic             tx_axis_udp_tready,
  input  logic [31:0]      tx_axis_icmp_tdata,
  input  logic             tx_axis_icmp_tvalid,
  input  logic             tx_axis_icmp_tlast,
  output logic             tx_axis_icmp_tready,
  output logic [31:0]      tx_axis_ip_tdata,
  output logic             tx_axis_ip_tvalid,
  output logic             tx_axis_ip_tlast,
  output logic             tx_axis_ip_tdest,
  input  logic             tx_axis_ip_tready,
  output logic [CNT_W-1:0] udp_pkt_cnt,
  output logic [CNT_W-1:0] icmp_pkt_cnt,
  output logic             overrun_err
);

  localparam int                BEAT_W    = $clog2(MAX_PKT_BEATS + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_PKT_BEATS - 1);

  arb_state_t          state, state_nxt;
  logic                last_grant, last_grant_nxt;
  logic [BEAT_W-1:0]   beat_cnt, beat_cnt_nxt;
  logic                overrun_nxt;
  logic                src_valid, src_last, src_ready;
  logic [31:0]         src_data;
  logic                s_valid, s_ready, m_valid;
  logic [SLICE_W-1:0]  s_data, m_data;

  // last_grant doubles as the current owner while a packet is in flight
  assign src_valid = (last_grant == TDEST_ICMP) ? tx_axis_icmp_tvalid : tx_axis_udp_tvalid;
  assign src_last  = (last_grant == TDEST_ICMP) ? tx_axis_icmp_tlast  : tx_axis_udp_tlast;
  assign src_data  = (last_grant == TDEST_ICMP) ? tx_axis_icmp_tdata  : tx_axis_udp_tdata;

  assign tx_axis_udp_tready  = src_ready && (last_grant == TDEST_UDP);
  assign tx_axis_icmp_tready = src_ready && (last_grant == TDEST_ICMP);

  assign s_data = {last_grant, src_last | (beat_cnt == LAST_BEAT), src_data};

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    beat_cnt_nxt   = beat_cnt;
    overrun_nxt    = 1'b0;
    src_ready      = 1'b0;
    s_valid        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (tx_axis_udp_tvalid || tx_axis_icmp_tvalid) begin
          if (tx_axis_udp_tvalid && tx_axis_icmp_tvalid) begin
            last_grant_nxt = FIXED_PRIO ? TDEST_ICMP : ~last_grant;
          end else begin
            last_grant_nxt = tx_axis_icmp_tvalid ? TDEST_ICMP : TDEST_UDP;
          end
          state_nxt    = (last_grant_nxt == TDEST_ICMP) ? ST_GNT_ICMP : ST_GNT_UDP;
          beat_cnt_nxt = '0;
        end
      end
      ST_GNT_UDP, ST_GNT_ICMP: begin
        src_ready = s_ready;
        if (src_valid && s_ready) begin
          s_valid      = 1'b1;
          beat_cnt_nxt = beat_cnt + BEAT_W'(1);
          if (src_last) begin
            state_nxt = ST_IDLE;
          end else if (beat_cnt == LAST_BEAT) begin
            state_nxt   = ST_DRAIN;
            overrun_nxt = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        src_ready = 1'b1;
        if (src_valid && src_last) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge tx_mac_aclk) begin
    if (tx_mac_reset) begin
      state        <= ST_IDLE;
      last_grant   <= TDEST_ICMP;
      beat_cnt     <= '0;
      overrun_err  <= 1'b0;
      udp_pkt_cnt  <= '0;
      icmp_pkt_cnt <= '0;
    end else begin
      state       <= state_nxt;
      last_grant  <= last_grant_nxt;
      beat_cnt    <= beat_cnt_nxt;
      overrun_err <= overrun_nxt;
      if (tx_axis_ip_tvalid && tx_axis_ip_tready && tx_axis_ip_tlast) begin
        if (tx_axis_ip_tdest == TDEST_ICMP) begin
          icmp_pkt_cnt <= icmp_pkt_cnt + CNT_W'(1);
        end else begin
          udp_pkt_cnt <= udp_pkt_cnt + CNT_W'(1);
        end
      end
    end
  end

  axis_reg_slice #(
    .WIDTH (SLICE_W)
  ) u_out_slice (
    .clk     (tx_mac_aclk),
    .rst     (tx_mac_reset),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (tx_axis_ip_tready),
    .m_data  (m_data)
  );

  assign tx_axis_ip_tvalid = m_valid;
  assign tx_axis_ip_tdest  = m_data[33];
  assign tx_axis_ip_tlast  = m_data[32];
  assign tx_axis_ip_tdata  = m_data[31:0];

endmodule

`default_nettype wire
